// File: rtl/sram_1rw_req_ctrl_pkg.sv
// Shared definitions for the 1RW SRAM request controller: default widths
// and the FSM state encoding.
package sram_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR      = 2'd1;
  localparam logic [1:0] ST_RD_ADDR = 2'd2;
  localparam logic [1:0] ST_RD_DATA = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    WR      = ST_WR,
    RD_ADDR = ST_RD_ADDR,
    RD_DATA = ST_RD_DATA
  } state_t;

endpackage

// File: rtl/sram_1rw_req_ctrl_if.sv
// Request/response handshake bundle between the bank arbiter (master)
// and the SRAM request controller (slave).
interface sram_1rw_req_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int DW = DATA_WIDTH_DEF,
  parameter int AW = ADDR_WIDTH_DEF
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_1rw_req_ctrl_rsp_slot.sv
// Single-entry valid/ready holding register for read data. Holds its word
// stable until the consumer pops it.
module sram_rsp_slot #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop_ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  // Load on push, clear on pop; the controller never pushes while full.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (valid && pop_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Upstream controller for a single-port 1RW SRAM macro. Turns a valid/ready
// request stream into registered CSb/WEb/OEb/address/data-drive sequences
// and returns read data through a one-entry response slot.
module sram_1rw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstb,
  sram_1rw_req_ctrl_if.slave    bus,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  state_t                state;
  state_t                state_nxt;
  logic                  csb_nxt;
  logic                  web_nxt;
  logic                  oeb_nxt;
  logic                  drive_nxt;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  req_ready;
  logic                  accept;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  assign req_ready     = rstb && (state == IDLE) && (!rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && req_ready;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;

  assign sram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  // Next state, and the pin levels that the next state will present.
  always_comb begin
    state_nxt = state;
    csb_nxt   = 1'b1;
    web_nxt   = 1'b1;
    oeb_nxt   = 1'b1;
    drive_nxt = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = bus.req_we ? WR : RD_ADDR;
      WR:      state_nxt = IDLE;
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    case (state_nxt)
      WR: begin
        csb_nxt   = 1'b0;
        web_nxt   = 1'b0;
        drive_nxt = 1'b1;
      end
      RD_ADDR: csb_nxt = 1'b0;
      RD_DATA: begin
        csb_nxt = 1'b0;
        oeb_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // State and pin registers; address and write data latch on accept.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= IDLE;
      sram_csb  <= 1'b1;
      sram_web  <= 1'b1;
      sram_oeb  <= 1'b1;
      drive_en  <= 1'b0;
      sram_addr <= '0;
      wdata_q   <= '0;
    end else begin
      state    <= state_nxt;
      sram_csb <= csb_nxt;
      sram_web <= web_nxt;
      sram_oeb <= oeb_nxt;
      drive_en <= drive_nxt;
      if (accept) begin
        sram_addr <= bus.req_addr;
        wdata_q   <= bus.req_wdata;
      end
    end
  end

  sram_rsp_slot #(.DW(DATA_WIDTH)) u_rsp_slot (
    .clk       (clk),
    .rstb      (rstb),
    .push      (state == RD_DATA),
    .push_data (sram_data),
    .pop_ready (bus.rsp_ready),
    .valid     (rsp_valid),
    .data      (rsp_rdata)
  );

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Directed self-checking bench for sram_1rw_req_ctrl with a behavioural
// 1RW SRAM model on the shared data bus.
module tb_sram_1rw_req_ctrl;

  localparam int DW = 32;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic sram_csb;
  logic sram_web;
  logic sram_oeb;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;

  int tests = 0;
  int fails = 0;
  int contention = 0;
  int strayDrive = 0;
  bit monitorOn = 1'b0;

  logic [DW-1:0] mem [0:2047];
  logic [DW-1:0] rdQ = '0;

  sram_1rw_req_ctrl_if #(.DW(DW), .AW(AW)) bus();

  sram_1rw_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .bus       (bus),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb),
    .sram_addr (sram_addr),
    .sram_data (sram_data)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // SRAM macro model: writes and address sampling on the clock edge.
  assign sram_data = (!sram_oeb) ? rdQ : {DW{1'bz}};

  // Sample SRAM pins on every edge like the macro would.
  always @(posedge clk) begin
    if (sram_csb == 1'b0) begin
      if (sram_web == 1'b0) mem[sram_addr] <= sram_data;
      else                  rdQ <= mem[sram_addr];
    end
  end

  // Watch for both sides driving the bus, or driving outside a write.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (!sram_oeb && dut.drive_en) contention <= contention + 1;
      if (sram_web && dut.drive_en) strayDrive <= strayDrive + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    tests++;
    fails++;
    $error("[TB] FAIL %s: bound expired, observed no handshake, expected one", tag);
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic doOp(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input string tag);
    int n;
    n = 0;
    applyStimulus(1'b1, we, addr, wdata);
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.req_ready) timeoutFail(tag);
    else tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input string tag, output logic [DW-1:0] data);
    int n;
    n = 0;
    data = '0;
    bus.rsp_ready = 1'b1;
    doOp(1'b0, addr, '0, tag);
    while (!bus.rsp_valid && n < 10) begin
      tick();
      n++;
    end
    if (!bus.rsp_valid) timeoutFail(tag);
    else data = bus.rsp_rdata;
    tick();
  endtask

  logic [DW-1:0] rd;
  logic [DW-1:0] rspQ[$];
  bit   opWe   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [DW-1:0] opData [4] = '{32'h1, 32'h0, 32'h2, 32'h0};
  int   acc    [4] = '{0, 0, 0, 0};
  int   stray;

  initial begin
    applyStimulus(1'b0, 1'b0, '0, '0);
    bus.rsp_ready = 1'b0;

    // Power-on reset
    rstb = 1'b0;
    tick();
    tick();
    monitorOn = 1'b1;
    checkOutput("rst csb", sram_csb, 1'b1);
    checkOutput("rst web", sram_web, 1'b1);
    checkOutput("rst oeb", sram_oeb, 1'b1);
    checkOutput("rst addr", sram_addr, '0);
    checkOutput("rst drive", dut.drive_en, 1'b0);
    checkOutput("rst rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("rst rsp_rdata", bus.rsp_rdata, '0);
    checkOutput("rst req_ready", bus.req_ready, 1'b0);
    rstb = 1'b1;
    #1;
    checkOutput("post-rst req_ready", bus.req_ready, 1'b1);

    // Write 0xDEADBEEF @0x7FF: pins active for exactly one cycle
    applyStimulus(1'b1, 1'b1, 11'h7FF, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("wr csb", sram_csb, 1'b0);
    checkOutput("wr web", sram_web, 1'b0);
    checkOutput("wr oeb", sram_oeb, 1'b1);
    checkOutput("wr addr", sram_addr, 11'h7FF);
    checkOutput("wr bus", sram_data, 32'hDEADBEEF);
    checkOutput("wr req_ready", bus.req_ready, 1'b0);
    tick();
    checkOutput("wr end csb", sram_csb, 1'b1);
    checkOutput("wr end web", sram_web, 1'b1);
    checkOutput("wr end drive", dut.drive_en, 1'b0);

    // Read @0x7FF: response two edges after accept
    bus.rsp_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 11'h7FF, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("rda csb", sram_csb, 1'b0);
    checkOutput("rda web", sram_web, 1'b1);
    checkOutput("rda oeb", sram_oeb, 1'b1);
    checkOutput("rda rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    checkOutput("rdd oeb", sram_oeb, 1'b0);
    checkOutput("rdd rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    checkOutput("rd rsp_valid", bus.rsp_valid, 1'b1);
    checkOutput("rd rdata", bus.rsp_rdata, 32'hDEADBEEF);
    checkOutput("rd idle csb", sram_csb, 1'b1);
    tick();
    checkOutput("rd popped", bus.rsp_valid, 1'b0);

    // Back-to-back W/R/W/R @0x001 with req_valid held high
    for (int cyc = 0; cyc < 40 && (rspQ.size() < 2); cyc++) begin
      if (bus.rsp_valid && bus.rsp_ready) rspQ.push_back(bus.rsp_rdata);
      if (rspQ.size() >= 2) break;
      if (acc[3] == 0 && !(opWe[3] == 1'b0 && rspQ.size() > 2)) begin end
      begin
        int idx;
        idx = 0;
        for (int k = 0; k < 4; k++) if (acc[k] != 0) idx = k + 1;
        if (idx < 4) begin
          applyStimulus(1'b1, opWe[idx], 11'h001, opData[idx]);
          if (bus.req_ready) acc[idx] = cyc + 1;
        end else begin
          applyStimulus(1'b0, 1'b0, '0, '0);
        end
      end
      tick();
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("b2b rsp count", 32'(rspQ.size()), 32'd2);
    if (rspQ.size() == 2) begin
      checkOutput("b2b rsp0", rspQ[0], 32'h1);
      checkOutput("b2b rsp1", rspQ[1], 32'h2);
    end
    checkOutput("b2b wr accept-to-accept", 32'(acc[1] - acc[0]), 32'd2);
    checkOutput("b2b rd accept-to-accept", 32'(acc[2] - acc[1]), 32'd3);
    tick();

    // Backpressure with two pending reads
    doOp(1'b1, 11'h010, 32'hA5A5A5A5, "bp wr0");
    doOp(1'b1, 11'h020, 32'h5A5A5A5A, "bp wr1");
    bus.rsp_ready = 1'b0;
    doOp(1'b0, 11'h010, '0, "bp rd0");
    applyStimulus(1'b1, 1'b0, 11'h020, '0);
    tick();
    tick();
    checkOutput("bp rsp_valid", bus.rsp_valid, 1'b1);
    checkOutput("bp rdata0", bus.rsp_rdata, 32'hA5A5A5A5);
    checkOutput("bp stall", bus.req_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("bp stall hold", bus.req_ready, 1'b0);
      checkOutput("bp rdata stable", bus.rsp_rdata, 32'hA5A5A5A5);
      checkOutput("bp csb idle", sram_csb, 1'b1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("pop+accept req_ready", bus.req_ready, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    bus.rsp_ready = 1'b0;
    checkOutput("bp popped", bus.rsp_valid, 1'b0);
    checkOutput("bp rd1 addr", sram_addr, 11'h020);
    checkOutput("bp rd1 csb", sram_csb, 1'b0);
    tick();
    tick();
    checkOutput("bp rsp1 valid", bus.rsp_valid, 1'b1);
    checkOutput("bp rdata1", bus.rsp_rdata, 32'h5A5A5A5A);
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("bp rsp1 popped", bus.rsp_valid, 1'b0);

    // Reset for two cycles in the middle of a read
    bus.rsp_ready = 1'b0;
    doOp(1'b0, 11'h7FF, '0, "rst rd");
    checkOutput("mid-rd csb", sram_csb, 1'b0);
    rstb = 1'b0;
    #1;
    checkOutput("in-rst req_ready", bus.req_ready, 1'b0);
    tick();
    tick();
    checkOutput("mid-rst csb", sram_csb, 1'b1);
    checkOutput("mid-rst web", sram_web, 1'b1);
    checkOutput("mid-rst oeb", sram_oeb, 1'b1);
    checkOutput("mid-rst drive", dut.drive_en, 1'b0);
    checkOutput("mid-rst rsp_valid", bus.rsp_valid, 1'b0);
    rstb = 1'b1;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.rsp_valid) stray++;
    end
    checkOutput("post-rst no response", 32'(stray), 32'd0);
    checkOutput("post-rst req_ready", bus.req_ready, 1'b1);

    // Address extremes hold distinct words
    doOp(1'b1, 11'h000, 32'h11111111, "wrap wr0");
    doOp(1'b1, 11'h7FF, 32'h22222222, "wrap wr1");
    doRead(11'h000, "wrap rd0", rd);
    checkOutput("wrap rdata 0x000", rd, 32'h11111111);
    doRead(11'h7FF, "wrap rd1", rd);
    checkOutput("wrap rdata 0x7FF", rd, 32'h22222222);

    tick();
    checkOutput("no bus contention", 32'(contention), 32'd0);
    checkOutput("no stray drive", 32'(strayDrive), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
